// File: rtl/particle_migration_dispatcher_pkg.sv
// Shared types and helpers for the particle migration dispatcher.
//   offset_data_t : packed x/y/z fixed-point offset
//   mig_pkt_t     : one migration FIFO entry {dest_x, dest_y, dest_z, offset, id, elem}
//   dest_coord()  : wrapped torus destination along one axis
package MD_pkg;

  localparam int OFFSET_WIDTH = 16;

  typedef struct packed {
    logic signed [OFFSET_WIDTH-1:0] x;
    logic signed [OFFSET_WIDTH-1:0] y;
    logic signed [OFFSET_WIDTH-1:0] z;
  } offset_data_t;

  localparam int OFFSET_STRUCT_WIDTH = $bits(offset_data_t);
  localparam int CELL_ID_WIDTH       = 2;
  localparam int PKT_ID_WIDTH        = 8;
  localparam int PKT_ELEM_WIDTH      = 2;

  localparam logic [1:0] CELL_MINUS = 2'd0;
  localparam logic [1:0] CELL_STAY  = 2'd1;
  localparam logic [1:0] CELL_PLUS  = 2'd2;

  typedef struct packed {
    logic [CELL_ID_WIDTH-1:0]  dest_x;
    logic [CELL_ID_WIDTH-1:0]  dest_y;
    logic [CELL_ID_WIDTH-1:0]  dest_z;
    offset_data_t              offset;
    logic [PKT_ID_WIDTH-1:0]   id;
    logic [PKT_ELEM_WIDTH-1:0] elem;
  } mig_pkt_t;

  // Code 3 (illegal) falls into the default arm and is treated as stay.
  function automatic logic [CELL_ID_WIDTH-1:0] dest_coord(input logic [1:0] code,
                                                          input int home, input int dim);
    int d;
    case (code)
      CELL_MINUS: d = (home == 0) ? dim - 1 : home - 1;
      CELL_PLUS:  d = (home == dim - 1) ? 0 : home + 1;
      default:    d = home;
    endcase
    return CELL_ID_WIDTH'(d);
  endfunction

endpackage

// File: rtl/particle_migration_dispatcher_fifo.sv
// First-word-fall-through FIFO of migration packets.
//   push/push_data : write one entry (caller guarantees !full || pop)
//   pop/pop_data   : head entry is visible whenever !empty; pop advances it
//   count/full/empty : occupancy status
// pop_data reads as zero while empty so the downstream data bus is quiet.
module migration_fifo
  import MD_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  mig_pkt_t                   push_data,
  input  logic                       pop,
  output mig_pkt_t                   pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  mig_pkt_t    mem [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= push_data;
  end

  assign count    = wr_ptr_q - rd_ptr_q;
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (count == (AW+1)'(DEPTH));
  assign pop_data = empty ? '0 : mem[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/particle_migration_dispatcher.sv
// Particle migration dispatcher.
// Splits converter results into home-cell write-backs (local port) and
// cross-boundary migrations (wrapped dest cell + payload through a FWFT FIFO
// to the ring), and runs the start/last/done phase handshake.
//   clk, rst (async, active-low), start
//   in_*    : upstream result; in_ready is advisory (FIFO count <= DEPTH-SLACK)
//   local_* : one-cycle write-back of particles that stay home
//   mig_*   : valid/ready migration stream
//   done, mig_count, overflow_err, code_err : phase status
//
// state | meaning
// IDLE  | waiting for start
// RUN   | classifying particles until in_last
// DRAIN | waiting for staged work and the FIFO to empty
// DONE  | one-cycle done pulse
module particle_migration_dispatcher
  import MD_pkg::*;
#(
  parameter int X_DIM      = 3,
  parameter int Y_DIM      = 3,
  parameter int Z_DIM      = 3,
  parameter int HOME_X     = 0,
  parameter int HOME_Y     = 0,
  parameter int HOME_Z     = 0,
  parameter int FIFO_DEPTH = 16,
  parameter int PIPE_SLACK = 4,
  parameter int ID_WIDTH   = PKT_ID_WIDTH,
  parameter int ELEM_WIDTH = PKT_ELEM_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           in_valid,
  input  logic                           in_last,
  input  logic [1:0]                     in_cell_x_offset,
  input  logic [1:0]                     in_cell_y_offset,
  input  logic [1:0]                     in_cell_z_offset,
  input  logic [OFFSET_STRUCT_WIDTH-1:0] in_offset,
  input  logic [ID_WIDTH-1:0]            in_id,
  input  logic [ELEM_WIDTH-1:0]          in_elem,
  output logic                           in_ready,
  output logic                           local_valid,
  output logic [OFFSET_STRUCT_WIDTH-1:0] local_offset,
  output logic [ID_WIDTH-1:0]            local_id,
  output logic [ELEM_WIDTH-1:0]          local_elem,
  output logic                           mig_valid,
  input  logic                           mig_ready,
  output logic [CELL_ID_WIDTH-1:0]       mig_dest_x,
  output logic [CELL_ID_WIDTH-1:0]       mig_dest_y,
  output logic [CELL_ID_WIDTH-1:0]       mig_dest_z,
  output logic [OFFSET_STRUCT_WIDTH-1:0] mig_offset,
  output logic [ID_WIDTH-1:0]            mig_id,
  output logic [ELEM_WIDTH-1:0]          mig_elem,
  output logic                           done,
  output logic [15:0]                    mig_count,
  output logic                           overflow_err,
  output logic                           code_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]                     state_q, state_d;
  logic                           local_valid_q, local_valid_d;
  logic [OFFSET_STRUCT_WIDTH-1:0] local_offset_q, local_offset_d;
  logic [ID_WIDTH-1:0]            local_id_q, local_id_d;
  logic [ELEM_WIDTH-1:0]          local_elem_q, local_elem_d;
  logic                           push_q, push_d;
  mig_pkt_t                       pkt_q, pkt_d;
  logic [15:0]                    mig_count_q, mig_count_d;
  logic                           overflow_err_q, overflow_err_d;
  logic                           code_err_q, code_err_d;

  logic                           fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]    fifo_count;
  mig_pkt_t                       fifo_head;
  logic [1:0]                     cx, cy, cz;
  logic                           illegal_code, stays_home;

  always_comb begin
    cx = (in_cell_x_offset == 2'd3) ? CELL_STAY : in_cell_x_offset;
    cy = (in_cell_y_offset == 2'd3) ? CELL_STAY : in_cell_y_offset;
    cz = (in_cell_z_offset == 2'd3) ? CELL_STAY : in_cell_z_offset;
    illegal_code = (in_cell_x_offset == 2'd3) || (in_cell_y_offset == 2'd3) ||
                   (in_cell_z_offset == 2'd3);
    stays_home   = (cx == CELL_STAY) && (cy == CELL_STAY) && (cz == CELL_STAY);
  end

  assign fifo_pop  = mig_valid && mig_ready;
  // A full FIFO still takes the write when the head leaves in the same cycle.
  assign fifo_push = push_q && (!fifo_full || fifo_pop);

  always_comb begin
    state_d        = state_q;
    local_valid_d  = 1'b0;
    local_offset_d = local_offset_q;
    local_id_d     = local_id_q;
    local_elem_d   = local_elem_q;
    push_d         = 1'b0;
    pkt_d          = pkt_q;
    mig_count_d    = mig_count_q;
    overflow_err_d = overflow_err_q;
    code_err_d     = code_err_q;

    if (push_q) begin
      if (fifo_push) mig_count_d = (mig_count_q == 16'hFFFF) ? mig_count_q : mig_count_q + 16'd1;
      else           overflow_err_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d        = S_RUN;
          mig_count_d    = '0;
          overflow_err_d = 1'b0;
          code_err_d     = 1'b0;
        end
      end
      S_RUN: begin
        if (in_valid) begin
          if (illegal_code) code_err_d = 1'b1;
          if (stays_home) begin
            local_valid_d  = 1'b1;
            local_offset_d = in_offset;
            local_id_d     = in_id;
            local_elem_d   = in_elem;
          end else begin
            push_d        = 1'b1;
            pkt_d.dest_x  = dest_coord(cx, HOME_X, X_DIM);
            pkt_d.dest_y  = dest_coord(cy, HOME_Y, Y_DIM);
            pkt_d.dest_z  = dest_coord(cz, HOME_Z, Z_DIM);
            pkt_d.offset  = offset_data_t'(in_offset);
            pkt_d.id      = PKT_ID_WIDTH'(in_id);
            pkt_d.elem    = PKT_ELEM_WIDTH'(in_elem);
          end
          if (in_last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Wait for the final particle to leave the output/staging register too,
        // so done never precedes the last local write-back or FIFO push.
        if (fifo_empty && !push_q && !local_valid_q) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    if (in_valid && state_q != S_RUN) code_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      local_valid_q  <= 1'b0;
      local_offset_q <= '0;
      local_id_q     <= '0;
      local_elem_q   <= '0;
      push_q         <= 1'b0;
      pkt_q          <= '0;
      mig_count_q    <= '0;
      overflow_err_q <= 1'b0;
      code_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      local_valid_q  <= local_valid_d;
      local_offset_q <= local_offset_d;
      local_id_q     <= local_id_d;
      local_elem_q   <= local_elem_d;
      push_q         <= push_d;
      pkt_q          <= pkt_d;
      mig_count_q    <= mig_count_d;
      overflow_err_q <= overflow_err_d;
      code_err_q     <= code_err_d;
    end
  end

  migration_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push      (fifo_push),
    .push_data (pkt_q),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign in_ready     = (int'(fifo_count) <= FIFO_DEPTH - PIPE_SLACK);
  assign local_valid  = local_valid_q;
  assign local_offset = local_offset_q;
  assign local_id     = local_id_q;
  assign local_elem   = local_elem_q;
  assign mig_valid    = !fifo_empty;
  assign mig_dest_x   = fifo_head.dest_x;
  assign mig_dest_y   = fifo_head.dest_y;
  assign mig_dest_z   = fifo_head.dest_z;
  assign mig_offset   = OFFSET_STRUCT_WIDTH'(fifo_head.offset);
  assign mig_id       = ID_WIDTH'(fifo_head.id);
  assign mig_elem     = ELEM_WIDTH'(fifo_head.elem);
  assign done         = (state_q == S_DONE);
  assign mig_count    = mig_count_q;
  assign overflow_err = overflow_err_q;
  assign code_err     = code_err_q;

endmodule
